fir_comp: RTL and testbench

Streaming complex FIR compute tile. It holds up to MAX_TAPS complex coefficients loaded by index, keeps a complex delay line of input samples, and produces one filtered sample per accepted input sample. It sits between the input formatter (upstream `from_input`/`ready`) and the output rate stage (downstream `to_output`/`next_ready`). A controller command (`from_cont`) configures it.

---
 rtl/fir_pkg.sv | 43 ++++
 rtl/fir_cmul.sv | 24 ++
 rtl/fir_comp.sv | 152 +++++++++++++++
 tb/tb_fir_comp.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the fir_comp streaming complex FIR tile.
// Holds the bus structs, the complex sample type, sizing constants, mode encodings
// and the controller state enum.
package fir_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_TAPS = 16;
    localparam int PROD_W   = 2 * DATA_W;
    localparam int ACC_W    = 2 * DATA_W + 4;
    localparam int NUM_W    = 5;
    localparam int IDX_W    = 4;

    localparam logic FIR_MODE_FIR = 1'b0;
    localparam logic FIR_MODE_BYP = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fir_state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] data_r;
        logic signed [DATA_W-1:0] data_i;
    } fir_cplx_t;

    typedef struct packed {
        logic             valid;
        logic [NUM_W-1:0] num;
        logic             mode;
    } FIR_CONT_TO_TILE;

    typedef struct packed {
        logic             valid;
        fir_cplx_t        data;
        logic [IDX_W-1:0] count;
    } FIR_TAP_LOAD;

    typedef struct packed {
        logic      valid;
        fir_cplx_t data;
    } FIR_DATA_BUS;

endpackage

// File: rtl/fir_cmul.sv
// fir_cmul: combinational complex multiplier, one per tap.
// (ar + j*ai) * (br + j*bi) = (ar*br - ai*bi) + j*(ar*bi + ai*br), kept at 2*DATA_W bits.
module fir_cmul
    import fir_pkg::*;
(
    input  fir_cplx_t                a,
    input  fir_cplx_t                b,
    output logic signed [PROD_W-1:0] p_r,
    output logic signed [PROD_W-1:0] p_i
);

    logic signed [PROD_W-1:0] ar, ai, br, bi;

    // Sign-extend the operands to product width, then form both complex terms.
    always_comb begin
        ar  = PROD_W'(a.data_r);
        ai  = PROD_W'(a.data_i);
        br  = PROD_W'(b.data_r);
        bi  = PROD_W'(b.data_i);
        p_r = (ar * br) - (ai * bi);
        p_i = (ar * bi) + (ai * br);
    end

endmodule

// File: rtl/fir_comp.sv
// fir_comp: streaming complex FIR tile with index-loaded taps and a complex delay line.
// One registered output per accepted input sample; fully parallel MAC over num taps.
// Build option: define FIR_SATURATE_EN to saturate each output component instead of
// wrapping to the low DATA_W bits of the accumulator.
module fir_comp
    import fir_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  FIR_CONT_TO_TILE from_cont,
    input  FIR_TAP_LOAD     input_tap,
    input  FIR_DATA_BUS     from_input,
    output logic            ready,
    output FIR_DATA_BUS     to_output,
    input  logic            next_ready
);

    fir_state_e               state_q, state_d;
    logic [NUM_W-1:0]         num_q, num_d;
    logic                     mode_q, mode_d;
    fir_cplx_t                taps_q [MAX_TAPS];
    fir_cplx_t                taps_d [MAX_TAPS];
    fir_cplx_t                x_q    [MAX_TAPS];
    fir_cplx_t                x_d    [MAX_TAPS];
    fir_cplx_t                x_shift[MAX_TAPS];
    FIR_DATA_BUS              out_q, out_d;
    logic signed [PROD_W-1:0] p_r [MAX_TAPS];
    logic signed [PROD_W-1:0] p_i [MAX_TAPS];
    logic signed [ACC_W-1:0]  acc_r, acc_i;
    fir_cplx_t                y;
    logic                     stall;
    logic                     accept;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    // Narrow one accumulator component to DATA_W bits (saturate or wrap).
    function automatic logic [DATA_W-1:0] reduce(input logic signed [ACC_W-1:0] acc);
`ifdef FIR_SATURATE_EN
        if (acc > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (acc < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return acc[DATA_W-1:0];
`else
        return acc[DATA_W-1:0];
`endif
    endfunction

    // Handshakes: a beat moves on a bus when valid and ready are both high at the
    // clock edge. to_output is held stable while valid && !next_ready; during that
    // stall ready is low, and a config command in the same cycle also blocks input.
    always_comb begin
        stall  = out_q.valid && !next_ready;
        ready  = (state_q == RUN) && !from_cont.valid && !stall;
        accept = from_input.valid && ready;
    end

    // Delay line as it will look after accepting the current sample.
    always_comb begin
        x_shift[0] = from_input.data;
        for (int k = 1; k < MAX_TAPS; k++) begin
            x_shift[k] = x_q[k-1];
        end
    end

    for (genvar g = 0; g < MAX_TAPS; g++) begin : g_mac
        fir_cmul u_cmul (
            .a   (taps_q[g]),
            .b   (x_shift[g]),
            .p_r (p_r[g]),
            .p_i (p_i[g])
        );
    end

    // Sum the first num products and pick FIR or bypass result.
    always_comb begin
        acc_r = '0;
        acc_i = '0;
        for (int k = 0; k < MAX_TAPS; k++) begin
            if (k < int'(num_q)) begin
                acc_r = acc_r + ACC_W'(p_r[k]);
                acc_i = acc_i + ACC_W'(p_i[k]);
            end
        end
        if (mode_q == FIR_MODE_BYP) begin
            y = from_input.data;
        end else begin
            y.data_r = reduce(acc_r);
            y.data_i = reduce(acc_i);
        end
    end

    // Next-state: FSM, tap writes, config latch, delay-line shift and output register.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        mode_d  = mode_q;
        taps_d  = taps_q;
        x_d     = x_q;
        out_d   = out_q;

        // Taps written now are seen by the multipliers from the next cycle on.
        if (input_tap.valid) begin
            taps_d[input_tap.count] = input_tap.data;
        end

        if (from_cont.valid) begin
            state_d = RUN;
            num_d   = (from_cont.num > NUM_W'(MAX_TAPS)) ? NUM_W'(MAX_TAPS) : from_cont.num;
            mode_d  = from_cont.mode;
            for (int k = 0; k < MAX_TAPS; k++) begin
                x_d[k] = '0;
            end
        end else if (accept) begin
            x_d = x_shift;
        end

        if (!stall) begin
            out_d.valid = accept;
            if (accept) begin
                out_d.data = y;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            mode_q  <= FIR_MODE_FIR;
            out_q   <= '0;
            for (int k = 0; k < MAX_TAPS; k++) begin
                taps_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            for (int k = 0; k < MAX_TAPS; k++) begin
                taps_q[k] <= taps_d[k];
                x_q[k]    <= x_d[k];
            end
        end
    end

    assign to_output = out_q;

endmodule

// File: tb/tb_fir_comp.sv
// tb_fir_comp: self-checking bench for fir_comp. Honours FIR_SATURATE_EN when defined.
`timescale 1ns/1ps
module tb_fir_comp;
    import fir_pkg::*;

    logic            clk;
    logic            rst_n;
    FIR_CONT_TO_TILE from_cont;
    FIR_TAP_LOAD     input_tap;
    FIR_DATA_BUS     from_input;
    logic            ready;
    FIR_DATA_BUS     to_output;
    logic            next_ready;

    fir_comp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .from_cont  (from_cont),
        .input_tap  (input_tap),
        .from_input (from_input),
        .ready      (ready),
        .to_output  (to_output),
        .next_ready (next_ready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus.
    typedef struct {
        bit rst;
        bit cv;  int cnum; bit cmode;
        bit tv;  int tidx; int tr; int ti;
        bit iv;  int xr;   int xi;
        bit nr;
    } cyc_t;

    // Directed single-shot records: configure, load h[0..1], feed samples, check last output.
    typedef struct {
        int num; bit mode;
        int h0r; int h0i; int h1r; int h1i;
        int nsamp;
        int x0r; int x0i; int x1r; int x1i;
        int er;  int ei;
    } vec_t;

    int n_tests;
    int n_fail;

    // ---------------- reference model ----------------
    int          h_r [MAX_TAPS];
    int          h_i [MAX_TAPS];
    int          x_r [MAX_TAPS];
    int          x_i [MAX_TAPS];
    int          m_num;
    bit          m_mode;
    bit          m_run;
    bit          m_out_v;
    bit          m_acc;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] red(input longint v);
`ifdef FIR_SATURATE_EN
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic [31:0] model_y(input int xr, input int xi);
        longint sr, si;
        if (m_mode) return {16'(xr), 16'(xi)};
        sr = 0;
        si = 0;
        for (int k = 0; k < m_num; k++) begin
            sr += longint'(h_r[k]) * x_r[k] - longint'(h_i[k]) * x_i[k];
            si += longint'(h_r[k]) * x_i[k] + longint'(h_i[k]) * x_r[k];
        end
        return {red(sr), red(si)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < MAX_TAPS; k++) begin
            h_r[k] = 0; h_i[k] = 0; x_r[k] = 0; x_i[k] = 0;
        end
        m_num = 0; m_mode = 0; m_run = 0; m_out_v = 0; m_acc = 0;
        exp_q.delete();
    endtask

    // Closed-form output of the 6-tap ramp filter h[k] = k+1 fed with x = 1,2,3,...
    function automatic int fir_ref(input int n);
        int s;
        s = 0;
        for (int k = 0; k < 6; k++) begin
            if (n - k >= 1) s += (k + 1) * (n - k);
        end
        return s;
    endfunction

    // ---------------- driver + scoreboard ----------------
    task automatic step(input cyc_t c);
        bit          exp_rdy;
        logic [31:0] y;
        logic [31:0] got;
        rst_n                  = c.rst;
        from_cont.valid        = c.cv;
        from_cont.num          = 5'(c.cnum);
        from_cont.mode         = c.cmode;
        input_tap.valid        = c.tv;
        input_tap.count        = 4'(c.tidx);
        input_tap.data.data_r  = 16'(c.tr);
        input_tap.data.data_i  = 16'(c.ti);
        from_input.valid       = c.iv;
        from_input.data.data_r = 16'(c.xr);
        from_input.data.data_i = 16'(c.xi);
        next_ready             = c.nr;
        #1;
        exp_rdy = m_run && !c.cv && (c.nr || !m_out_v);
        if (!c.rst) chk("ready", 32'(ready), 32'(exp_rdy));
        if (to_output.valid === 1'b1 && c.nr) begin
            got = to_output.data;
            obs_q.push_back(got);
        end
        m_acc = 0;
        y     = '0;
        if (c.rst) begin
            model_reset();
        end else begin
            if (m_out_v && c.nr && exp_q.size() > 0) void'(exp_q.pop_front());
            m_acc = c.iv && exp_rdy;
            if (m_acc) begin
                for (int k = MAX_TAPS - 1; k > 0; k--) begin
                    x_r[k] = x_r[k-1];
                    x_i[k] = x_i[k-1];
                end
                x_r[0] = c.xr;
                x_i[0] = c.xi;
                y = model_y(c.xr, c.xi);
            end
            if (!(m_out_v && !c.nr)) begin
                m_out_v = m_acc;
                if (m_acc) exp_q.push_back(y);
            end
            if (c.tv) begin
                h_r[c.tidx] = c.tr;
                h_i[c.tidx] = c.ti;
            end
            if (c.cv) begin
                m_run  = 1;
                m_num  = (c.cnum > MAX_TAPS) ? MAX_TAPS : c.cnum;
                m_mode = c.cmode;
                for (int k = 0; k < MAX_TAPS; k++) begin
                    x_r[k] = 0;
                    x_i[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(to_output.valid), 32'(m_out_v));
        if (c.rst) begin
            chk("rst_out_data", to_output.data, 32'h0);
        end else if (m_out_v && exp_q.size() > 0) begin
            chk("out_data", to_output.data, exp_q[0]);
        end
    endtask

    function automatic cyc_t nop();
        cyc_t c;
        c = '{default: 0};
        c.nr = 1;
        return c;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(nop());
    endtask

    task automatic do_reset();
        cyc_t c;
        c = nop();
        c.rst = 1;
        step(c);
    endtask

    task automatic cfg(input int num, input bit mode);
        cyc_t c;
        c = nop();
        c.cv = 1; c.cnum = num; c.cmode = mode;
        step(c);
    endtask

    task automatic tap(input int idx, input int r, input int i);
        cyc_t c;
        c = nop();
        c.tv = 1; c.tidx = idx; c.tr = r; c.ti = i;
        step(c);
    endtask

    task automatic smp(input int r, input int i);
        cyc_t c;
        c = nop();
        c.iv = 1; c.xr = r; c.xi = i;
        step(c);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65534)) - 32767;
    endfunction

    // ---------------- test sequence ----------------
    vec_t tbl[6];
    int   first7[7];

    initial begin
        cyc_t c;
        int   s;
        int   stalls;
        int   guard;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst_n = 1'b0; from_cont = '0; input_tap = '0; from_input = '0; next_ready = 1'b1;
        #1;

        // Reset state.
        do_reset();
        step(nop());
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_out", 32'(to_output), 32'h0);

        // Basic FIR: h[k] = k+1, stream 1..64.
        for (int k = 0; k < 6; k++) tap(k, k + 1, 0);
        cfg(6, FIR_MODE_FIR);
        obs_q.delete();
        for (int n = 1; n <= 64; n++) smp(n, 0);
        idle(2);
        first7 = '{1, 4, 10, 20, 35, 56, 77};
        chk("fir_count", 32'(obs_q.size()), 32'd64);
        for (int i = 0; i < 7 && i < obs_q.size(); i++)
            chk("fir_head", obs_q[i], {16'(first7[i]), 16'h0});
        for (int i = 0; i < obs_q.size(); i++)
            chk("fir_ramp", obs_q[i], {16'(fir_ref(i + 1)), 16'h0});
        if (obs_q.size() == 64) chk("fir_last", obs_q[63], {16'd1274, 16'h0});

        // Backpressure: next_ready low for 3 cycles after 30 samples.
        cfg(6, FIR_MODE_FIR);
        obs_q.delete();
        s = 1; stalls = 0; guard = 0;
        while (s <= 64 && guard < 300) begin
            c = nop();
            c.iv = 1; c.xr = s;
            if (s == 31 && stalls < 3) begin
                c.nr = 0;
                stalls++;
            end
            step(c);
            if (c.nr == 0) begin
                chk("bp_held", to_output.data, {16'(fir_ref(30)), 16'h0});
                chk("bp_ready_low", 32'(ready), 32'h0);
            end
            if (m_acc) s++;
            guard++;
        end
        chk("bp_no_timeout", 32'(s), 32'd65);
        idle(2);
        chk("bp_count", 32'(obs_q.size()), 32'd64);
        for (int i = 0; i < obs_q.size(); i++)
            chk("bp_ramp", obs_q[i], {16'(fir_ref(i + 1)), 16'h0});

        // Reset mid-stream clears everything, including taps.
        cfg(6, FIR_MODE_FIR);
        for (int n = 1; n <= 10; n++) smp(n, 0);
        c = nop();
        c.rst = 1; c.iv = 1; c.xr = 11;
        step(c);
        chk("rst_mid_out", 32'(to_output), 32'h0);
        step(nop());
        chk("rst_mid_idle", 32'(ready), 32'h0);
        cfg(1, FIR_MODE_FIR);
        smp(9, 9);
        chk("rst_taps_zero", to_output.data, 32'h0);

        // Reconfig clears the delay line; tap load alongside a sample applies next sample.
        tap(0, 3, 0);
        tap(1, 5, 0);
        cfg(2, FIR_MODE_FIR);
        smp(7, 0);
        chk("recfg_first", to_output.data, {16'd21, 16'd0});
        smp(2, 0);
        chk("recfg_second", to_output.data, {16'd41, 16'd0});
        cfg(2, FIR_MODE_FIR);
        smp(4, 0);
        chk("recfg_cleared", to_output.data, {16'd12, 16'd0});
        c = nop();
        c.iv = 1; c.xr = 1; c.tv = 1; c.tidx = 0; c.tr = 10;
        step(c);
        chk("tap_same_cycle", to_output.data, {16'd23, 16'd0});
        smp(1, 0);
        chk("tap_next_sample", to_output.data, {16'd15, 16'd0});

        // Config and sample in the same cycle: config wins.
        c = nop();
        c.cv = 1; c.cnum = 1; c.iv = 1; c.xr = 6;
        step(c);
        chk("cfg_wins_valid", 32'(to_output.valid), 32'h0);

        // Directed table.
        tbl[0] = '{num:1,  mode:0, h0r:0,     h0i:1,  h1r:0,     h1i:0,  nsamp:1,
                   x0r:3,     x0i:4,  x1r:0,     x1i:0,  er:-4,  ei:3};
        tbl[1] = '{num:1,  mode:1, h0r:0,     h0i:0,  h1r:0,     h1i:0,  nsamp:1,
                   x0r:5,     x0i:-2, x1r:0,     x1i:0,  er:5,   ei:-2};
`ifdef FIR_SATURATE_EN
        tbl[2] = '{num:2,  mode:0, h0r:32767, h0i:0,  h1r:32767, h1i:0,  nsamp:2,
                   x0r:32767, x0i:0,  x1r:32767, x1i:0,  er:32767, ei:0};
`else
        tbl[2] = '{num:2,  mode:0, h0r:32767, h0i:0,  h1r:32767, h1i:0,  nsamp:2,
                   x0r:32767, x0i:0,  x1r:32767, x1i:0,  er:2,   ei:0};
`endif
        tbl[3] = '{num:0,  mode:0, h0r:9,     h0i:9,  h1r:9,     h1i:9,  nsamp:2,
                   x0r:100,   x0i:7,  x1r:3,     x1i:1,  er:0,   ei:0};
        tbl[4] = '{num:31, mode:0, h0r:2,     h0i:0,  h1r:7,     h1i:7,  nsamp:1,
                   x0r:3,     x0i:3,  x1r:0,     x1i:0,  er:6,   ei:6};
        tbl[5] = '{num:2,  mode:0, h0r:1,     h0i:2,  h1r:3,     h1i:-1, nsamp:2,
                   x0r:2,     x0i:1,  x1r:-1,    x1i:4,  er:-2,  ei:3};
        for (int v = 0; v < 6; v++) begin
            tap(0, tbl[v].h0r, tbl[v].h0i);
            tap(1, tbl[v].h1r, tbl[v].h1i);
            cfg(tbl[v].num, tbl[v].mode);
            smp(tbl[v].x0r, tbl[v].x0i);
            if (tbl[v].nsamp == 2) smp(tbl[v].x1r, tbl[v].x1i);
            chk($sformatf("tbl%0d", v), to_output.data, {16'(tbl[v].er), 16'(tbl[v].ei)});
            idle(1);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < MAX_TAPS; k++) tap(k, rnd16(), rnd16());
        cfg(8, FIR_MODE_FIR);
        for (int i = 0; i < 1500; i++) begin
            c = nop();
            c.nr = ($urandom_range(0, 99) < 75);
            c.iv = ($urandom_range(0, 99) < 70);
            c.xr = rnd16();
            c.xi = rnd16();
            if ($urandom_range(0, 99) < 10) begin
                c.tv = 1; c.tidx = int'($urandom_range(0, 15)); c.tr = rnd16(); c.ti = rnd16();
            end
            if ($urandom_range(0, 99) < 3) begin
                c.cv = 1; c.cnum = int'($urandom_range(0, 31));
                c.cmode = ($urandom_range(0, 99) < 20);
            end
            step(c);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
